// File: rtl/axi_txn_sequencer.sv
// Arbitrates write/read requesters round-robin and sequences one AXI master transaction at a time.
// Optional `TXN_TIMEOUT_EN` adds a WAIT watchdog that forces an error response after TIMEOUT_CYC cycles.
module axi_txn_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LEN_W       = 9,
  parameter int unsigned NUM_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              iWR_VALID,
  input  logic              iRD_VALID,
  output logic              oWR_READY,
  output logic              oRD_READY,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  input  logic [LEN_W-1:0]  iWR_LEN,
  input  logic [LEN_W-1:0]  iRD_LEN,
  input  logic [NUM_W-1:0]  iWR_NUM,
  input  logic [NUM_W-1:0]  iRD_NUM,
  output logic              oRSP_VALID,
  output logic              oRSP_ID,
  output logic              oRSP_ERR,
  output logic [ADDR_W-1:0] oSLV_BASE_WADDR,
  output logic [ADDR_W-1:0] oSLV_BASE_RADDR,
  output logic [NUM_W-1:0]  oNUM_BURST,
  output logic [LEN_W-1:0]  oBURST_LEN,
  output logic              oOP_TYPE,
  output logic              oINIT_AXI_TXN,
  input  logic              iAXI_TXN_DONE,
  input  logic              iAXI_ERROR,
  output logic              oBUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

  state_t            state;
  logic              last_rd;
  logic              grant_wr;
  logic              grant_rd;
  logic [LEN_W-1:0]  sel_len;
  logic [NUM_W-1:0]  sel_num;
  logic              sel_bad;

  // Round-robin pick: with both requesting, serve the one not granted last.
  always_comb begin
    grant_wr = iWR_VALID && (!iRD_VALID || last_rd);
    grant_rd = iRD_VALID && !grant_wr;
    sel_len  = grant_rd ? iRD_LEN : iWR_LEN;
    sel_num  = grant_rd ? iRD_NUM : iWR_NUM;
    sel_bad  = (sel_len == '0) || (32'(sel_len) > 32'd256) || (sel_num == '0);
  end

`ifdef TXN_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && !iAXI_TXN_DONE) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state           <= ST_IDLE;
      last_rd         <= 1'b1;
      oWR_READY       <= 1'b0;
      oRD_READY       <= 1'b0;
      oRSP_VALID      <= 1'b0;
      oRSP_ID         <= 1'b0;
      oRSP_ERR        <= 1'b0;
      oSLV_BASE_WADDR <= '0;
      oSLV_BASE_RADDR <= '0;
      oNUM_BURST      <= '0;
      oBURST_LEN      <= '0;
      oOP_TYPE        <= 1'b0;
      oINIT_AXI_TXN   <= 1'b0;
      oBUSY           <= 1'b0;
    end else begin
      oWR_READY     <= 1'b0;
      oRD_READY     <= 1'b0;
      oINIT_AXI_TXN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_wr || grant_rd) begin
            oWR_READY <= grant_wr;
            oRD_READY <= grant_rd;
            last_rd   <= grant_rd;
            oRSP_ID   <= grant_rd;
            oRSP_ERR  <= sel_bad;
            oBUSY     <= 1'b1;
            if (sel_bad) begin
              state <= ST_RESP;
            end else begin
              state      <= ST_LAUNCH;
              oOP_TYPE   <= grant_rd;
              oBURST_LEN <= sel_len;
              oNUM_BURST <= sel_num;
              if (grant_rd) oSLV_BASE_RADDR <= iRD_ADDR;
              else          oSLV_BASE_WADDR <= iWR_ADDR;
            end
          end
        end
        ST_LAUNCH: begin
          state         <= ST_WAIT;
          oINIT_AXI_TXN <= 1'b1;
        end
        ST_WAIT: begin
          if (iAXI_TXN_DONE) begin
            state      <= ST_RESP;
            oRSP_VALID <= 1'b1;
            oRSP_ERR   <= iAXI_ERROR;
          end
`ifdef TXN_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state      <= ST_RESP;
            oRSP_VALID <= 1'b1;
            oRSP_ERR   <= 1'b1;
          end
`endif
        end
        ST_RESP: begin
          // Rejected commands arrive here without the strobe; give it one cycle later.
          if (oRSP_VALID) begin
            state      <= ST_IDLE;
            oRSP_VALID <= 1'b0;
            oBUSY      <= 1'b0;
          end else begin
            oRSP_VALID <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Self-checking bench for axi_txn_sequencer: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, validity and address holdover.
module tb_axi_txn_sequencer;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned NUM_W  = 32;
  localparam int unsigned TO     = 16;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              iWR_VALID, iRD_VALID, oWR_READY, oRD_READY;
  logic [ADDR_W-1:0] iWR_ADDR, iRD_ADDR;
  logic [LEN_W-1:0]  iWR_LEN, iRD_LEN;
  logic [NUM_W-1:0]  iWR_NUM, iRD_NUM;
  logic              oRSP_VALID, oRSP_ID, oRSP_ERR;
  logic [ADDR_W-1:0] oSLV_BASE_WADDR, oSLV_BASE_RADDR;
  logic [NUM_W-1:0]  oNUM_BURST;
  logic [LEN_W-1:0]  oBURST_LEN;
  logic              oOP_TYPE, oINIT_AXI_TXN, iAXI_TXN_DONE, iAXI_ERROR, oBUSY;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state
  bit          m_last_rd;
  logic [31:0] m_waddr;
  logic [31:0] m_raddr;

  axi_txn_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .NUM_W(NUM_W), .TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .iWR_VALID(iWR_VALID), .iRD_VALID(iRD_VALID),
    .oWR_READY(oWR_READY), .oRD_READY(oRD_READY),
    .iWR_ADDR(iWR_ADDR), .iRD_ADDR(iRD_ADDR),
    .iWR_LEN(iWR_LEN), .iRD_LEN(iRD_LEN),
    .iWR_NUM(iWR_NUM), .iRD_NUM(iRD_NUM),
    .oRSP_VALID(oRSP_VALID), .oRSP_ID(oRSP_ID), .oRSP_ERR(oRSP_ERR),
    .oSLV_BASE_WADDR(oSLV_BASE_WADDR), .oSLV_BASE_RADDR(oSLV_BASE_RADDR),
    .oNUM_BURST(oNUM_BURST), .oBURST_LEN(oBURST_LEN), .oOP_TYPE(oOP_TYPE),
    .oINIT_AXI_TXN(oINIT_AXI_TXN), .iAXI_TXN_DONE(iAXI_TXN_DONE),
    .iAXI_ERROR(iAXI_ERROR), .oBUSY(oBUSY)
  );

  always #5 ACLK = ~ACLK;

  function automatic bit pick_rd(bit wv, bit rv);
    if (wv && rv) return !m_last_rd;
    return rv;
  endfunction

  function automatic bit is_bad(int len, logic [31:0] num);
    return (len == 0) || (len > 256) || (num == 32'd0);
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({oWR_READY, oRD_READY, oRSP_VALID, oRSP_ID, oRSP_ERR, oSLV_BASE_WADDR,
                 oSLV_BASE_RADDR, oNUM_BURST, oBURST_LEN, oOP_TYPE, oINIT_AXI_TXN, oBUSY});
  endfunction

  task automatic clear_inputs;
    iWR_VALID = 0; iRD_VALID = 0; iAXI_TXN_DONE = 0; iAXI_ERROR = 0;
    iWR_ADDR = '0; iRD_ADDR = '0; iWR_LEN = '0; iRD_LEN = '0; iWR_NUM = '0; iRD_NUM = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    ARESET = 1;
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    m_last_rd = 1; m_waddr = '0; m_raddr = '0;
  endtask

  task automatic wait_grant(output bit seen);
    int n = 0;
    @(negedge ACLK);
    while (!(oWR_READY || oRD_READY) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    seen = oWR_READY || oRD_READY;
  endtask

  task automatic test_reset;
    clear_inputs();
    ARESET = 1;
    iWR_VALID = 1; iWR_LEN = 9'd4; iWR_NUM = 32'd1;
    repeat (2) @(negedge ACLK);
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outs got %h required 0", all_outs());
    end
    ARESET = 0;
    clear_inputs();
    m_last_rd = 1; m_waddr = '0; m_raddr = '0;
    @(negedge ACLK);
    checks++;
    if (oBUSY !== 1'b0 || oWR_READY !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b wr_ready=%b required 0/0", oBUSY, oWR_READY);
    end
  endtask

  task automatic test_write;
    bit seen;
    int inits, early;
    iWR_ADDR = 32'h8000_0000; iWR_LEN = 9'd8; iWR_NUM = 32'd1; iWR_VALID = 1;
    wait_grant(seen);
    iWR_VALID = 0;
    checks++;
    if (!seen || oWR_READY !== 1'b1 || oRD_READY !== 1'b0) begin
      errors++; $display("FAIL wr_grant wr_ready=%b rd_ready=%b required 1/0", oWR_READY, oRD_READY);
    end
    checks++;
    if (oOP_TYPE !== 1'b0 || oSLV_BASE_WADDR !== 32'h8000_0000 || oBURST_LEN !== 9'd8 ||
        oNUM_BURST !== 32'd1 || oBUSY !== 1'b1 || oINIT_AXI_TXN !== 1'b0) begin
      errors++; $display("FAIL wr_launch op=%b waddr=%h len=%0d num=%0d busy=%b init=%b required 0/80000000/8/1/1/0",
                         oOP_TYPE, oSLV_BASE_WADDR, oBURST_LEN, oNUM_BURST, oBUSY, oINIT_AXI_TXN);
    end
    @(negedge ACLK);
    checks++;
    if (oINIT_AXI_TXN !== 1'b1) begin
      errors++; $display("FAIL wr_init_t1 got %b required 1", oINIT_AXI_TXN);
    end
    inits = 1; early = 0;
    repeat (20) begin
      @(negedge ACLK);
      inits += int'(oINIT_AXI_TXN);
      early += int'(oRSP_VALID);
    end
    checks++;
    if (inits != 1 || early != 0) begin
      errors++; $display("FAIL wr_pulses init_count=%0d early_rsp=%0d required 1/0", inits, early);
    end
    iAXI_TXN_DONE = 1;
    @(negedge ACLK);
    iAXI_TXN_DONE = 0;
    checks++;
    if (oRSP_VALID !== 1'b1 || oRSP_ID !== 1'b0 || oRSP_ERR !== 1'b0 || oSLV_BASE_WADDR !== 32'h8000_0000) begin
      errors++; $display("FAIL wr_rsp valid=%b id=%b err=%b waddr=%h required 1/0/0/80000000",
                         oRSP_VALID, oRSP_ID, oRSP_ERR, oSLV_BASE_WADDR);
    end
    @(negedge ACLK);
    checks++;
    if (oRSP_VALID !== 1'b0 || oBUSY !== 1'b0) begin
      errors++; $display("FAIL wr_rsp_end valid=%b busy=%b required 0/0", oRSP_VALID, oBUSY);
    end
    m_last_rd = 0; m_waddr = 32'h8000_0000;
  endtask

  task automatic test_round_robin;
    bit seen;
    do_reset();
    iWR_ADDR = 32'h1000; iWR_LEN = 9'd4; iWR_NUM = 32'd2;
    iRD_ADDR = 32'h2000; iRD_LEN = 9'd16; iRD_NUM = 32'd3;
    iWR_VALID = 1; iRD_VALID = 1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(seen);
      checks++;
      if (!seen || oRD_READY !== 1'(i % 2) || oWR_READY !== 1'(1 - i % 2)) begin
        errors++; $display("FAIL rr_order%0d wr_ready=%b rd_ready=%b required rd=%0d", i, oWR_READY, oRD_READY, i % 2);
      end
      if (oRD_READY) iRD_VALID = 0;
      else           iWR_VALID = 0;
      @(negedge ACLK);
      iAXI_TXN_DONE = 1;
      @(negedge ACLK);
      iAXI_TXN_DONE = 0;
      checks++;
      if (oRSP_VALID !== 1'b1 || oRSP_ID !== 1'(i % 2)) begin
        errors++; $display("FAIL rr_rsp%0d valid=%b id=%b required 1/%0d", i, oRSP_VALID, oRSP_ID, i % 2);
      end
      iWR_VALID = 1; iRD_VALID = 1;
    end
    iWR_VALID = 0; iRD_VALID = 0;
    @(negedge ACLK);
    m_last_rd = 1; m_waddr = 32'h1000; m_raddr = 32'h2000;
  endtask

  task automatic test_invalid;
    int          lens[3] = '{257, 0, 8};
    logic [31:0] nums[3] = '{32'd1, 32'd1, 32'd0};
    bit seen;
    for (int i = 0; i < 3; i++) begin
      iRD_ADDR = 32'hDEAD_0000 + 32'(i); iRD_LEN = LEN_W'(lens[i]); iRD_NUM = nums[i]; iRD_VALID = 1;
      wait_grant(seen);
      iRD_VALID = 0;
      checks++;
      if (!seen || oRD_READY !== 1'b1 || oRSP_VALID !== 1'b0 || oINIT_AXI_TXN !== 1'b0) begin
        errors++; $display("FAIL inv_grant%0d rd_ready=%b rsp=%b init=%b required 1/0/0", i, oRD_READY, oRSP_VALID, oINIT_AXI_TXN);
      end
      @(negedge ACLK);
      checks++;
      if (oRSP_VALID !== 1'b1 || oRSP_ERR !== 1'b1 || oRSP_ID !== 1'b1 || oINIT_AXI_TXN !== 1'b0 ||
          oSLV_BASE_RADDR !== m_raddr) begin
        errors++; $display("FAIL inv_rsp%0d valid=%b err=%b id=%b init=%b raddr=%h required 1/1/1/0/%h",
                           i, oRSP_VALID, oRSP_ERR, oRSP_ID, oINIT_AXI_TXN, oSLV_BASE_RADDR, m_raddr);
      end
      @(negedge ACLK);
      checks++;
      if (oRSP_VALID !== 1'b0 || oINIT_AXI_TXN !== 1'b0) begin
        errors++; $display("FAIL inv_end%0d rsp=%b init=%b required 0/0", i, oRSP_VALID, oINIT_AXI_TXN);
      end
      m_last_rd = 1;
    end
  endtask

  task automatic test_error_launch_done;
    bit seen;
    int early = 0;
    iWR_ADDR = 32'h0000_4400; iWR_LEN = 9'd256; iWR_NUM = 32'd5; iWR_VALID = 1;
    wait_grant(seen);
    iWR_VALID = 0;
    iAXI_TXN_DONE = 1;
    @(negedge ACLK);
    iAXI_TXN_DONE = 0;
    checks++;
    if (!seen || oINIT_AXI_TXN !== 1'b1) begin
      errors++; $display("FAIL eld_init seen=%b init=%b required 1/1", seen, oINIT_AXI_TXN);
    end
    repeat (4) begin
      @(negedge ACLK);
      early += int'(oRSP_VALID);
    end
    checks++;
    if (early != 0 || oBUSY !== 1'b1) begin
      errors++; $display("FAIL eld_ignored rsp_count=%0d busy=%b required 0/1", early, oBUSY);
    end
    iAXI_TXN_DONE = 1; iAXI_ERROR = 1;
    @(negedge ACLK);
    iAXI_TXN_DONE = 0; iAXI_ERROR = 0;
    checks++;
    if (oRSP_VALID !== 1'b1 || oRSP_ERR !== 1'b1 || oRSP_ID !== 1'b0) begin
      errors++; $display("FAIL eld_err valid=%b err=%b id=%b required 1/1/0", oRSP_VALID, oRSP_ERR, oRSP_ID);
    end
    @(negedge ACLK);
    m_last_rd = 0; m_waddr = 32'h0000_4400;
  endtask

  task automatic test_timeout;
    bit seen;
    int early = 0;
    iRD_ADDR = 32'h0BAD_F00D; iRD_LEN = 9'd2; iRD_NUM = 32'd1; iRD_VALID = 1;
    wait_grant(seen);
    iRD_VALID = 0;
`ifdef TXN_TIMEOUT_EN
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge ACLK);
      early += int'(oRSP_VALID);
    end
    @(negedge ACLK);
    checks++;
    if (!seen || early != 0 || oRSP_VALID !== 1'b1 || oRSP_ERR !== 1'b1 || oRSP_ID !== 1'b1) begin
      errors++; $display("FAIL timeout early=%0d valid=%b err=%b id=%b required 0/1/1/1", early, oRSP_VALID, oRSP_ERR, oRSP_ID);
    end
    @(negedge ACLK);
`else
    repeat (40) begin
      @(negedge ACLK);
      early += int'(oRSP_VALID);
    end
    checks++;
    if (!seen || early != 0 || oBUSY !== 1'b1) begin
      errors++; $display("FAIL no_timeout rsp_count=%0d busy=%b required 0/1", early, oBUSY);
    end
    iAXI_TXN_DONE = 1;
    @(negedge ACLK);
    iAXI_TXN_DONE = 0;
    checks++;
    if (oRSP_VALID !== 1'b1 || oRSP_ERR !== 1'b0) begin
      errors++; $display("FAIL late_done valid=%b err=%b required 1/0", oRSP_VALID, oRSP_ERR);
    end
    @(negedge ACLK);
`endif
    m_last_rd = 1; m_raddr = 32'h0BAD_F00D;
  endtask

  task automatic test_reset_mid;
    bit seen;
    int early = 0;
    iWR_ADDR = 32'h5555_0000; iWR_LEN = 9'd1; iWR_NUM = 32'd1; iWR_VALID = 1;
    wait_grant(seen);
    iWR_VALID = 0;
    repeat (2) @(negedge ACLK);
    #2 ARESET = 1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL async_reset got %h required 0", all_outs());
    end
    @(negedge ACLK);
    iAXI_TXN_DONE = 1;
    @(negedge ACLK);
    ARESET = 0; iAXI_TXN_DONE = 0;
    m_last_rd = 1; m_waddr = '0; m_raddr = '0;
    repeat (3) begin
      @(negedge ACLK);
      early += int'(oRSP_VALID);
    end
    checks++;
    if (early != 0 || oBUSY !== 1'b0) begin
      errors++; $display("FAIL abort_no_rsp rsp_count=%0d busy=%b required 0/0", early, oBUSY);
    end
    iWR_ADDR = 32'h6666_0000; iWR_LEN = 9'd3; iWR_NUM = 32'd4; iWR_VALID = 1;
    iRD_ADDR = 32'h7777_0000; iRD_LEN = 9'd3; iRD_NUM = 32'd4; iRD_VALID = 1;
    wait_grant(seen);
    iWR_VALID = 0; iRD_VALID = 0;
    checks++;
    if (!seen || oWR_READY !== 1'b1 || oSLV_BASE_WADDR !== 32'h6666_0000 || oSLV_BASE_RADDR !== 32'h0) begin
      errors++; $display("FAIL post_reset_grant wr_ready=%b waddr=%h raddr=%h required 1/66660000/0",
                         oWR_READY, oSLV_BASE_WADDR, oSLV_BASE_RADDR);
    end
    @(negedge ACLK);
    iAXI_TXN_DONE = 1;
    @(negedge ACLK);
    iAXI_TXN_DONE = 0;
    checks++;
    if (oRSP_VALID !== 1'b1 || oRSP_ID !== 1'b0 || oRSP_ERR !== 1'b0) begin
      errors++; $display("FAIL post_reset_rsp valid=%b id=%b err=%b required 1/0/0", oRSP_VALID, oRSP_ID, oRSP_ERR);
    end
    @(negedge ACLK);
    m_last_rd = 0; m_waddr = 32'h6666_0000;
  endtask

  task automatic test_random;
    bit          seen, wv, rv, exp_rd, bad, e;
    int          pat, wl, rl, len, d, early;
    logic [31:0] wa, ra, wn, rn, addr, num;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      pat = int'($urandom_range(0, 2));
      wv = (pat != 1); rv = (pat != 0);
      wa = $urandom; ra = $urandom;
      wl = 0; rl = 0;
      for (int s = 0; s < 2; s++) begin
        case ($urandom_range(0, 9))
          0:       len = 0;
          1:       len = 257 + int'($urandom_range(0, 254));
          2:       len = 256;
          default: len = int'($urandom_range(1, 255));
        endcase
        if (s == 0) wl = len; else rl = len;
      end
      wn = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      rn = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      exp_rd = pick_rd(wv, rv);
      len  = exp_rd ? rl : wl;
      num  = exp_rd ? rn : wn;
      addr = exp_rd ? ra : wa;
      bad  = is_bad(len, num);
      iWR_ADDR = wa; iWR_LEN = LEN_W'(wl); iWR_NUM = wn; iWR_VALID = wv;
      iRD_ADDR = ra; iRD_LEN = LEN_W'(rl); iRD_NUM = rn; iRD_VALID = rv;
      wait_grant(seen);
      iWR_VALID = 0; iRD_VALID = 0;
      checks++;
      if (!seen || oRD_READY !== exp_rd || oWR_READY !== !exp_rd) begin
        errors++; $display("FAIL rnd_grant%0d wr_ready=%b rd_ready=%b required rd=%b", t, oWR_READY, oRD_READY, exp_rd);
      end
      m_last_rd = exp_rd;
      if (bad) begin
        @(negedge ACLK);
        checks++;
        if (oRSP_VALID !== 1'b1 || oRSP_ERR !== 1'b1 || oRSP_ID !== exp_rd || oINIT_AXI_TXN !== 1'b0 ||
            oSLV_BASE_WADDR !== m_waddr || oSLV_BASE_RADDR !== m_raddr) begin
          errors++; $display("FAIL rnd_inv%0d valid=%b err=%b id=%b init=%b waddr=%h raddr=%h required 1/1/%b/0/%h/%h",
                             t, oRSP_VALID, oRSP_ERR, oRSP_ID, oINIT_AXI_TXN, oSLV_BASE_WADDR, oSLV_BASE_RADDR,
                             exp_rd, m_waddr, m_raddr);
        end
      end else begin
        if (exp_rd) m_raddr = addr; else m_waddr = addr;
        checks++;
        if (oOP_TYPE !== exp_rd || oBURST_LEN !== LEN_W'(len) || oNUM_BURST !== num ||
            oSLV_BASE_WADDR !== m_waddr || oSLV_BASE_RADDR !== m_raddr) begin
          errors++; $display("FAIL rnd_cmd%0d op=%b len=%0d num=%0d waddr=%h raddr=%h required %b/%0d/%0d/%h/%h",
                             t, oOP_TYPE, oBURST_LEN, oNUM_BURST, oSLV_BASE_WADDR, oSLV_BASE_RADDR,
                             exp_rd, len, num, m_waddr, m_raddr);
        end
        @(negedge ACLK);
        checks++;
        if (oINIT_AXI_TXN !== 1'b1) begin
          errors++; $display("FAIL rnd_init%0d got %b required 1", t, oINIT_AXI_TXN);
        end
        d = int'($urandom_range(0, 5));
        early = 0;
        repeat (d) begin
          @(negedge ACLK);
          early += int'(oRSP_VALID);
        end
        e = 1'($urandom_range(0, 1));
        iAXI_TXN_DONE = 1; iAXI_ERROR = e;
        @(negedge ACLK);
        iAXI_TXN_DONE = 0; iAXI_ERROR = 0;
        checks++;
        if (early != 0 || oRSP_VALID !== 1'b1 || oRSP_ID !== exp_rd || oRSP_ERR !== e) begin
          errors++; $display("FAIL rnd_rsp%0d early=%0d valid=%b id=%b err=%b required 0/1/%b/%b",
                             t, early, oRSP_VALID, oRSP_ID, oRSP_ERR, exp_rd, e);
        end
      end
      @(negedge ACLK);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_invalid();
    test_error_launch_done();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
